// File: rtl/insn_pack.sv
// RV32I instruction encoder with a valid/ready input and a small output FIFO.
// Define INSN_PACK_RANGE_CHK_EN to flag unrepresentable immediates / illegal fmt on err.
module insn_pack #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fmt,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      insn,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [31:0]   pk_insn;
   logic          pk_err;
   logic          push;
   logic          pop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [32:0]   mem [DEPTH];
   logic [32:0]   last_q;
   logic [32:0]   head;

   // Packing is purely combinational; out-of-range immediates are simply truncated.
   always_comb begin
      pk_insn = 32'h0;
      case (fmt)
         FMT_R: pk_insn = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: pk_insn = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S: pk_insn = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: pk_insn = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U: pk_insn = {imm[31:12], rd, opcode};
         FMT_J: pk_insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: pk_insn = 32'h0;
      endcase
   end

`ifdef INSN_PACK_RANGE_CHK_EN
   always_comb begin
      pk_err = 1'b0;
      case (fmt)
         FMT_R:        pk_err = 1'b0;
         FMT_I, FMT_S: pk_err = !((&imm[31:11]) || !(|imm[31:11]));
         FMT_B:        pk_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         FMT_U:        pk_err = |imm[11:0];
         FMT_J:        pk_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         default:      pk_err = 1'b1;
      endcase
   end

   // Counts accepted err words, sticking at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (push && pk_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   assign pk_err  = 1'b0;
   assign err_cnt = '0;
`endif

   assign in_ready  = !rst && (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {pk_err, pk_insn};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Once drained, the outputs keep showing the last word handed out.
   assign head = out_valid ? mem[rd_ptr] : last_q;
   assign insn = head[31:0];
   assign err  = head[32];

endmodule

// File: tb/tb_insn_pack.sv
// Directed bench for insn_pack: reset flush, formats, back-pressure, streaming, range errors.
// Expected err/err_cnt follow whether INSN_PACK_RANGE_CHK_EN is defined for the build.
module tb_insn_pack;

`ifdef INSN_PACK_RANGE_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] insn;
   logic        err;
   logic [7:0]  err_cnt;

   logic        s_in_valid;
   logic        s_in_ready;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [31:0] s_insn;
   logic        s_err;
   logic [1:0]  s_err_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   insn_pack #(.DEPTH(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .insn(insn), .err(err), .err_cnt(err_cnt)
   );

   // Narrow counter instance fed only illegal-fmt words.
   insn_pack #(.DEPTH(2), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .fmt(3'd6), .opcode(7'h13), .rd(5'd1), .rs1(5'd2), .rs2(5'd3),
      .funct3(3'd0), .funct7(7'd0), .imm(32'd0),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .insn(s_insn), .err(s_err), .err_cnt(s_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
   endtask

   function automatic logic [31:0] uw(input logic [19:0] k);
      return {k, 5'd0, 7'h37};
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      set_in(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (insn !== 32'h0) $display("FAIL rst_insn got=%h exp=0", insn); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      set_in(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL q2_out_valid got=%b exp=1", out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL q2_in_ready got=%b exp=0", in_ready); else pass_cnt++;
      total_cnt++; if (err_cnt !== (CHK ? 8'd2 : 8'd0)) $display("FAIL q2_err_cnt got=%0d exp=%0d", err_cnt, CHK ? 2 : 0); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (insn !== 32'h0) $display("FAIL mid_rst_insn got=%h exp=0", insn); else pass_cnt++;
      total_cnt++; if (err_cnt !== 8'd0) $display("FAIL mid_rst_err_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
   endtask

   task automatic test_formats();
      logic [2:0]  tf  [5];
      logic [6:0]  top [5];
      logic [4:0]  trd [5];
      logic [4:0]  ts1 [5];
      logic [4:0]  ts2 [5];
      logic [2:0]  tf3 [5];
      logic [31:0] tim [5];
      logic [31:0] texp[5];
      tf   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      top  = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6f};
      trd  = '{5'd7, 5'd0, 5'd0, 5'd4, 5'd15};
      ts1  = '{5'd5, 5'd1, 5'd6, 5'd0, 5'd0};
      ts2  = '{5'd0, 5'd10, 5'd8, 5'd0, 5'd0};
      tf3  = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd0};
      tim  = '{32'd333, 32'd321, 32'd998, 32'hff806000, 32'hfffffb2e};
      texp = '{32'h14d28393, 32'h14a0a0a3, 32'h3e831363, 32'hff806237, 32'hb2fff7ef};
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_in(tf[i], top[i], trd[i], ts1[i], ts2[i], tf3[i], 7'd0, tim[i]);
         in_valid = 1'b1;
         @(negedge clk);
         total_cnt++; if (out_valid !== 1'b1) $display("FAIL fmt%0d_out_valid got=%b exp=1", i, out_valid); else pass_cnt++;
         total_cnt++; if (insn !== texp[i]) $display("FAIL fmt%0d_insn got=%h exp=%h", i, insn, texp[i]); else pass_cnt++;
         total_cnt++; if (err !== 1'b0) $display("FAIL fmt%0d_err got=%b exp=0", i, err); else pass_cnt++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL fmt_drain_out_valid got=%b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (insn !== 32'hb2fff7ef) $display("FAIL fmt_hold_insn got=%h exp=b2fff7ef", insn); else pass_cnt++;
   endtask

   task automatic test_back_pressure();
      @(negedge clk);
      out_ready = 1'b0;
      set_in(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {20'h000a1, 12'h0});
      in_valid = 1'b1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_rdy0 got=%b exp=1", in_ready); else pass_cnt++;
      @(negedge clk);
      set_in(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {20'h000b2, 12'h0});
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_rdy1 got=%b exp=1", in_ready); else pass_cnt++;
      @(negedge clk);
      set_in(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {20'h000c3, 12'h0});
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_rdy got=%b exp=0", in_ready); else pass_cnt++;
      total_cnt++; if (insn !== uw(20'h000a1)) $display("FAIL bp_head_a got=%h exp=%h", insn, uw(20'h000a1)); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (insn !== uw(20'h000a1)) $display("FAIL bp_hold_a got=%h exp=%h", insn, uw(20'h000a1)); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", out_valid); else pass_cnt++;
      out_ready = 1'b1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_rdy2 got=%b exp=0", in_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (insn !== uw(20'h000b2)) $display("FAIL bp_head_b got=%h exp=%h", insn, uw(20'h000b2)); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_rdy_back got=%b exp=1", in_ready); else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (insn !== uw(20'h000c3)) $display("FAIL bp_head_c got=%h exp=%h", insn, uw(20'h000c3)); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [19:0] k;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         k = 20'(i * 'h111 + 1);
         set_in(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {k, 12'h0});
         in_valid = 1'b1;
         @(negedge clk);
         total_cnt++; if (insn !== uw(k) || out_valid !== 1'b1) $display("FAIL b2b%0d_insn got=%h/%b exp=%h/1", i, insn, out_valid, uw(k)); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_in_ready got=%b exp=1", i, in_ready); else pass_cnt++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", out_valid); else pass_cnt++;
   endtask

   task automatic test_range();
      logic [2:0]  tf  [4];
      logic [6:0]  top [4];
      logic [31:0] tim [4];
      logic [31:0] texp[4];
      logic        terr[4];
      tf   = '{3'd1, 3'd1, 3'd3, 3'd6};
      top  = '{7'h13, 7'h13, 7'h63, 7'h13};
      tim  = '{32'd2048, 32'hfffff800, 32'd7, 32'd5};
      texp = '{32'h80000013, 32'h80000013, 32'h00000363, 32'h00000000};
      terr = '{CHK, 1'b0, CHK, CHK};
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_in(tf[i], top[i], 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, tim[i]);
         in_valid = 1'b1;
         @(negedge clk);
         total_cnt++; if (insn !== texp[i]) $display("FAIL rng%0d_insn got=%h exp=%h", i, insn, texp[i]); else pass_cnt++;
         total_cnt++; if (err !== terr[i]) $display("FAIL rng%0d_err got=%b exp=%b", i, err, terr[i]); else pass_cnt++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (err_cnt !== (CHK ? 8'd3 : 8'd0)) $display("FAIL rng_err_cnt got=%0d exp=%0d", err_cnt, CHK ? 3 : 0); else pass_cnt++;
   endtask

   task automatic test_saturation();
      @(negedge clk);
      s_out_ready = 1'b1;
      s_in_valid = 1'b1;
      total_cnt++; if (s_in_ready !== 1'b1) $display("FAIL sat_in_ready got=%b exp=1", s_in_ready); else pass_cnt++;
      repeat (2) @(negedge clk);
      total_cnt++; if (s_err_cnt !== (CHK ? 2'd2 : 2'd0)) $display("FAIL sat_cnt2 got=%0d exp=%0d", s_err_cnt, CHK ? 2 : 0); else pass_cnt++;
      repeat (3) @(negedge clk);
      s_in_valid = 1'b0;
      total_cnt++; if (s_err_cnt !== (CHK ? 2'd3 : 2'd0)) $display("FAIL sat_cnt5 got=%0d exp=%0d", s_err_cnt, CHK ? 3 : 0); else pass_cnt++;
      total_cnt++; if (s_insn !== 32'h0 || s_out_valid !== 1'b1) $display("FAIL sat_insn got=%h/%b exp=0/1", s_insn, s_out_valid); else pass_cnt++;
      total_cnt++; if (s_err !== CHK) $display("FAIL sat_err got=%b exp=%b", s_err, CHK); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (s_out_valid !== 1'b0) $display("FAIL sat_drain got=%b exp=0", s_out_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_formats();
      test_back_pressure();
      test_back_to_back();
      test_range();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
